// File: rtl/mvm_par_lanes_pkg.sv
// Shared types and sizing helpers for the parallel-lane matrix-vector multiplier.
// MVM_PIPE_MULT_EN adds a product register in each lane, which lengthens FLUSH by one cycle.
package mvm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_X,
        COMPUTE,
        FLUSH,
        OUTPUT
    } state_t;

`ifdef MVM_PIPE_MULT_EN
    localparam int PIPE_STAGES = 1;
`else
    localparam int PIPE_STAGES = 0;
`endif

    // Product width plus headroom for K accumulations; this can never overflow.
    function automatic int out_width(input int b, input int k);
        return 2 * b + $clog2(k);
    endfunction

    // Width for a counter over n values, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mvm_par_lanes_if.sv
// Streaming command, element-input and result-output bundle of the matrix-vector multiplier.
interface mvm_par_lanes_if #(
    parameter int B  = 8,
    parameter int OW = 21
);
    logic                 load_matrix;
    logic                 load_vector;
    logic                 start;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [B-1:0]  data_in;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [OW-1:0] data_out;
    logic                 busy;
    logic                 done;

    modport master (
        output load_matrix, load_vector, start, in_valid, data_in, out_ready,
        input  in_ready, out_valid, data_out, busy, done
    );

    modport slave (
        input  load_matrix, load_vector, start, in_valid, data_in, out_ready,
        output in_ready, out_valid, data_out, busy, done
    );
endinterface

// File: rtl/mvm_par_lanes_lane.sv
// One MAC lane: a bank of matrix rows, a signed multiplier and a full-precision accumulator.
// With MVM_PIPE_MULT_EN a register stage sits between the multiplier and the adder.
module mvm_lane
    import mvm_pkg::*;
#(
    parameter int K  = 32,
    parameter int P  = 4,
    parameter int B  = 8,
    parameter int OW = out_width(8, 32),
    parameter int AW = cnt_width(32 * 32 / 4)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_wr_en,
    input  logic [AW-1:0]        i_wr_addr,
    input  logic signed [B-1:0]  i_wr_data,
    input  logic [AW-1:0]        i_rd_addr,
    input  logic                 i_vld_p0,
    input  logic                 i_first_p0,
    input  logic signed [B-1:0]  i_x_p0,
    output logic signed [OW-1:0] o_acc
);
    localparam int DEPTH = K * K / P;

    logic signed [B-1:0]   r_bank [DEPTH];
    logic signed [B-1:0]   r_a_p0;
    logic signed [2*B-1:0] w_prod_p0;
    logic signed [2*B-1:0] w_prod;
    logic                  w_vld;
    logic                  w_first;
    logic signed [OW-1:0]  r_acc;

    function automatic logic signed [OW-1:0] sext_prod(input logic signed [2*B-1:0] p);
        return OW'(p);
    endfunction

    always_ff @(posedge clk) begin
        if (i_wr_en)
            r_bank[i_wr_addr] <= i_wr_data;
        r_a_p0 <= r_bank[i_rd_addr];
    end

    // p0: bank word and x element arrive together, one cycle after the read address
    assign w_prod_p0 = r_a_p0 * i_x_p0;

`ifdef MVM_PIPE_MULT_EN
    logic signed [2*B-1:0] r_prod_p1;
    logic                  r_vld_p1;
    logic                  r_first_p1;

    // p1: registered product
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vld_p1   <= 1'b0;
            r_first_p1 <= 1'b0;
        end else begin
            r_vld_p1   <= i_vld_p0;
            r_first_p1 <= i_first_p0;
        end
    end

    always_ff @(posedge clk)
        r_prod_p1 <= w_prod_p0;

    assign w_prod  = r_prod_p1;
    assign w_vld   = r_vld_p1;
    assign w_first = r_first_p1;
`else
    assign w_prod  = w_prod_p0;
    assign w_vld   = i_vld_p0;
    assign w_first = i_first_p0;
`endif

    // First product of a row group loads the accumulator so groups run back to back.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_acc <= '0;
        else if (w_vld)
            r_acc <= w_first ? sext_prod(w_prod) : r_acc + sext_prod(w_prod);
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/mvm_par_lanes.sv
// Matrix-vector multiplier y = A*x with P parallel MAC lanes and valid/ready streaming.
// Build option MVM_PIPE_MULT_EN pipelines every lane multiplier (group latency K+3 instead of K+2).
module mvm_par_lanes
    import mvm_pkg::*;
#(
    parameter int K = 32,
    parameter int P = 4,
    parameter int B = 8
) (
    input logic            clk,
    input logic            reset,
    mvm_par_lanes_if.slave bus
);
    localparam int OW = out_width(B, K);
    localparam int G  = K / P;
    localparam int AW = cnt_width(K * K / P);
    localparam int CW = cnt_width(K);
    localparam int LW = cnt_width(P);
    localparam int GW = cnt_width(G);

    state_t               r_state;
    logic [CW-1:0]        r_col;
    logic [LW-1:0]        r_lane;
    logic [GW-1:0]        r_grp;
    logic                 r_tail;
    logic [1:0]           r_fcnt;
    logic [CW-1:0]        r_oidx;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic                 r_done;
    logic                 r_vld_p0;
    logic                 r_first_p0;
    logic signed [B-1:0]  r_x_p0;
    logic signed [B-1:0]  r_xmem [K];
    logic signed [OW-1:0] r_ymem [K];

    logic [AW-1:0]        w_addr;
    logic                 w_in_hs;
    logic                 w_out_hs;
    logic                 w_issue;
    logic                 w_y_wr;
    logic                 w_last_col;
    logic                 w_last_lane;
    logic                 w_last_grp;
    logic signed [OW-1:0] w_acc [P];

    // Row group and column address a lane bank for both loading and computing.
    assign w_addr      = AW'(int'(r_grp) * K + int'(r_col));
    assign w_in_hs     = bus.in_valid && r_in_ready;
    assign w_out_hs    = r_out_valid && bus.out_ready;
    assign w_issue     = (r_state == COMPUTE) && !r_tail;
    assign w_y_wr      = (r_state == FLUSH) && (r_fcnt == 2'(PIPE_STAGES));
    assign w_last_col  = (r_col == CW'(K - 1));
    assign w_last_lane = (r_lane == LW'(P - 1));
    assign w_last_grp  = (r_grp == GW'(G - 1));

    for (genvar l = 0; l < P; l++) begin : g_lane
        mvm_lane #(.K(K), .P(P), .B(B), .OW(OW), .AW(AW)) u_lane (
            .clk        (clk),
            .reset      (reset),
            .i_wr_en    ((r_state == LOAD_A) && w_in_hs && (r_lane == LW'(l))),
            .i_wr_addr  (w_addr),
            .i_wr_data  (bus.data_in),
            .i_rd_addr  (w_addr),
            .i_vld_p0   (r_vld_p0),
            .i_first_p0 (r_first_p0),
            .i_x_p0     (r_x_p0),
            .o_acc      (w_acc[l])
        );
    end

    always_ff @(posedge clk) begin
        if ((r_state == LOAD_X) && w_in_hs)
            r_xmem[r_col] <= bus.data_in;
        r_x_p0 <= r_xmem[r_col];
        if (w_y_wr)
            for (int l = 0; l < P; l++)
                r_ymem[CW'(int'(r_grp) * P + l)] <= w_acc[l];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_col       <= '0;
            r_lane      <= '0;
            r_grp       <= '0;
            r_tail      <= 1'b0;
            r_fcnt      <= '0;
            r_oidx      <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
            r_vld_p0    <= 1'b0;
            r_first_p0  <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_vld_p0   <= w_issue;
            r_first_p0 <= w_issue && (r_col == '0);
            case (r_state)
                IDLE: begin
                    r_col  <= '0;
                    r_lane <= '0;
                    r_grp  <= '0;
                    r_tail <= 1'b0;
                    r_fcnt <= '0;
                    if (bus.load_matrix) begin
                        r_state    <= LOAD_A;
                        r_in_ready <= 1'b1;
                    end else if (bus.load_vector) begin
                        r_state    <= LOAD_X;
                        r_in_ready <= 1'b1;
                    end else if (bus.start) begin
                        r_state <= COMPUTE;
                    end
                end
                LOAD_A: if (w_in_hs) begin
                    if (!w_last_col) begin
                        r_col <= r_col + CW'(1);
                    end else begin
                        r_col <= '0;
                        if (!w_last_lane) begin
                            r_lane <= r_lane + LW'(1);
                        end else begin
                            r_lane <= '0;
                            if (!w_last_grp) begin
                                r_grp <= r_grp + GW'(1);
                            end else begin
                                r_state    <= IDLE;
                                r_in_ready <= 1'b0;
                            end
                        end
                    end
                end
                LOAD_X: if (w_in_hs) begin
                    if (!w_last_col) begin
                        r_col <= r_col + CW'(1);
                    end else begin
                        r_col      <= '0;
                        r_state    <= IDLE;
                        r_in_ready <= 1'b0;
                    end
                end
                // The tail cycle covers the one-cycle bank read latency.
                COMPUTE: begin
                    if (!r_tail) begin
                        if (w_last_col) begin
                            r_col  <= '0;
                            r_tail <= 1'b1;
                        end else begin
                            r_col <= r_col + CW'(1);
                        end
                    end else begin
                        r_tail  <= 1'b0;
                        r_fcnt  <= '0;
                        r_state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (w_y_wr) begin
                        r_fcnt <= '0;
                        if (w_last_grp) begin
                            r_grp       <= '0;
                            r_oidx      <= '0;
                            r_out_valid <= 1'b1;
                            r_state     <= OUTPUT;
                        end else begin
                            r_grp   <= r_grp + GW'(1);
                            r_state <= COMPUTE;
                        end
                    end else begin
                        r_fcnt <= r_fcnt + 2'd1;
                    end
                end
                OUTPUT: if (w_out_hs) begin
                    if (r_oidx == CW'(K - 1)) begin
                        r_oidx      <= '0;
                        r_out_valid <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= IDLE;
                    end else begin
                        r_oidx <= r_oidx + CW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.data_out  = r_out_valid ? r_ymem[r_oidx] : '0;
    assign bus.busy      = (r_state != IDLE);
    assign bus.done      = r_done;

endmodule

// File: doc/mvm_par_lanes.md
Name: mvm_par_lanes

Overview:
- Next-generation matrix-vector multiplier: y = A·x for a signed KxK matrix A and a K-vector x.
- Uses P parallel MAC lanes, so each group of P output rows completes in one pass over x.
- Replaces single-MAC, fixed-handshake MVM instances.
- Adds valid/ready streaming on input and output, full-precision accumulation, and an explicit busy indication.

Parameters:
- K, 32, matrix dimension and vector length; K >= 2.
- P, 4, number of parallel MAC lanes; P >= 1 and K % P == 0.
- B, 8, signed input element width.
- OW (localparam), 2*B+$clog2(K), signed output width; guarantees no overflow.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- load_matrix  in  1  pulse: begin loading K*K elements of A, row-major
- load_vector  in  1  pulse: begin loading K elements of x
- start  in  1  pulse: begin computation
- in_valid  in  1  data_in holds a valid element
- in_ready  out  1  block accepts an element this cycle
- data_in  in  B  signed element
- out_valid  out  1  data_out holds a valid y element
- out_ready  in  1  consumer accepts data_out this cycle
- data_out  out  OW  signed y element, y[0] first
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last y element is accepted

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high.
- Reset values:
  - State goes to IDLE.
  - in_ready=0, out_valid=0, data_out=0, busy=0, done=0.
  - All counters and accumulators = 0.
  - A, x and y storage is not cleared.
- States: IDLE, LOAD_A, LOAD_X, COMPUTE, FLUSH, OUTPUT.
- IDLE command handling:
  - Commands are sampled only in IDLE; elsewhere they are ignored.
  - Priority when simultaneous: load_matrix > load_vector > start.
- LOAD_A:
  - in_ready=1.
  - Each handshake (in_valid && in_ready) stores element index n = r*K + c into lane r%P at bank address (r/P)*K + c.
  - in_valid low stalls the load; the counter holds.
  - After the K*K-th handshake: in_ready drops the next cycle and the state returns to IDLE.
- LOAD_X: same as LOAD_A but accepts K elements into x storage, then returns to IDLE.
- COMPUTE:
  - Processes row groups g = 0..K/P-1.
  - For each g, column counter c runs 0..K-1, one column per cycle.
  - Each cycle reads x[c] and every lane's bank at g*K + c.
  - Memory read latency is 1 cycle.
  - Each lane computes acc += sext(a)*sext(x) at OW bits.
  - acc is cleared on the first product of each group (load, not add) — no idle cycle between groups.
- FLUSH:
  - Waits for the pipeline to drain: 1 cycle, or 2 with the optional feature.
  - Writes lane l's acc into y[g*P + l] for all lanes in the same cycle.
  - Next state: COMPUTE if g < K/P-1, else OUTPUT.
- Per-group latency: K + 2 cycles (K + 3 with the optional feature). This is fixed and verifiable.
- OUTPUT:
  - Streams y[0..K-1] with out_valid=1.
  - data_out must stay stable while out_valid && !out_ready.
  - The index advances only on a handshake.
  - After the K-th handshake: out_valid=0 and done=1 for exactly one cycle, with the state returning to IDLE in that same cycle.
- start with A or x never loaded: computes on current storage contents; no error flag.
- Reset mid-operation: immediate return to IDLE; a partially loaded A or x is left partially overwritten.
- P=1 degenerates to a single MAC; P=K completes all rows in one pass.

Optional Feature:
- Macro: MVM_PIPE_MULT_EN.
- Defined: a register stage is inserted between multiplier and adder in every lane. FLUSH lasts 2 cycles and per-group latency is K+3.
- Undefined: multiply and accumulate happen in the same cycle. FLUSH lasts 1 cycle and per-group latency is K+2.
- Arithmetic results are identical in both builds.

Decomposition:
- Package mvm_pkg:
  - state_t enum (IDLE, LOAD_A, LOAD_X, COMPUTE, FLUSH, OUTPUT).
  - Function out_width(B, K).
  - Localparam PIPE_STAGES, derived from MVM_PIPE_MULT_EN.
- Sub-module mvm_lane, instantiated P times via generate. Each lane contains:
  - one bank of K*K/P words of B bits;
  - the multiplier, with the optional pipeline register;
  - the OW-bit accumulator with its clear-on-first-product control.
- The top level holds the FSM, the counters, the x storage and the y storage.

Test Plan:
- K=4, P=2, A=identity, x=[1,2,3,4], out_ready=1 -> y=[1,2,3,4]; done pulses once; busy is low the following cycle.
- K=32, P=4, all A=-128, all x=-128 -> every y=524288. With all A=-128 and x=127 -> every y=-520192 (no overflow at OW=21).
- Random A and x with in_valid randomly low 50% of cycles -> no elements dropped; y matches the golden model; in_ready is low outside LOAD states.
- out_ready toggled 1,0,0,1,... during OUTPUT -> data_out is stable while stalled; exactly K handshakes; no duplicates.
- load_matrix and start asserted together in IDLE -> LOAD_A is entered. Assert reset during COMPUTE of group 2 -> all outputs return to reset values immediately. A subsequent start recomputes correct y from the retained A and x.
- Timing check: measure cycles from start to first out_valid = (K/P)*(K+2)+1, or (K/P)*(K+3)+1 with MVM_PIPE_MULT_EN defined. Run both builds.
